// File: rtl/sprite_rom_arbiter_if.sv
// rtl/sprite_rom_arbiter_if.sv - requester/ROM bundle for the sprite ROM arbiter
//
// Purpose: groups the three requester read ports, the grant vector, the
// shared synchronous sprite ROM port and the tagged read-data return.
// Signals:
//   req[2:0]           per-requester read request (0 knight, 1 enemy, 2 background)
//   addr0/addr1/addr2  14-bit ROM address of each requester, valid while req[i]=1
//   gnt[2:0]           combinational one-hot grant from the arbiter
//   rom_address        registered address driven to the sprite ROM
//   rom_q              ROM palette index, one cycle after rom_address
//   rdata              registered read data shared by all requesters
//   rvalid[2:0]        registered one-hot owner of rdata
// Modports: slave = arbiter view, master = requesters plus ROM view.
interface sprite_rom_arbiter_if;
  logic [2:0]  req;
  logic [13:0] addr0;
  logic [13:0] addr1;
  logic [13:0] addr2;
  logic [2:0]  gnt;
  logic [13:0] rom_address;
  logic [2:0]  rom_q;
  logic [2:0]  rdata;
  logic [2:0]  rvalid;

  modport slave (
    input  req, addr0, addr1, addr2, rom_q,
    output gnt, rom_address, rdata, rvalid
  );

  modport master (
    output req, addr0, addr1, addr2, rom_q,
    input  gnt, rom_address, rdata, rvalid
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - three-way arbiter in front of one synchronous sprite ROM
//
// Purpose: shares a single synchronous sprite ROM between the knight, enemy
// and background requesters at one read per cycle. The winner's address is
// registered onto rom_address; a one-hot tag follows the read so rdata and
// rvalid appear together two cycles after the accepting edge.
// Ports:
//   vga_clk  sole clock, rising edge
//   Reset    asynchronous active-high reset
//   bus      sprite_rom_arbiter_if.slave (req, addr0..2, gnt, rom_address,
//            rom_q, rdata, rvalid)
// Configuration macro: SPRITE_ARB_RR_EN
//   defined   - round-robin from a 2-bit last-grant pointer
//   undefined - fixed priority 0 > 1 > 2, no pointer
module sprite_rom_arbiter (
  input  logic                  vga_clk,
  input  logic                  Reset,
  sprite_rom_arbiter_if.slave   bus
);

  logic [2:0]  w_gnt;
  logic        w_accept;
  logic [13:0] w_win_addr;

  logic [13:0] r_rom_address;
  logic [2:0]  r_tag1;
  logic [2:0]  r_tag2;
  logic [2:0]  r_rdata;
  logic [2:0]  r_rvalid;

`ifdef SPRITE_ARB_RR_EN
  logic [1:0] r_ptr;
  logic [1:0] w_p0;
  logic [1:0] w_p1;
  logic [1:0] w_p2;
  logic [1:0] w_win_idx;

  // Priority order starts just after the last winner and wraps mod 3.
  always_comb begin
    w_p0 = 2'd0;
    w_p1 = 2'd1;
    w_p2 = 2'd2;
    case (r_ptr)
      2'd0: begin w_p0 = 2'd1; w_p1 = 2'd2; w_p2 = 2'd0; end
      2'd1: begin w_p0 = 2'd2; w_p1 = 2'd0; w_p2 = 2'd1; end
      default: ;
    endcase
    w_gnt = 3'b000;
    if (|(bus.req & (3'b001 << w_p0)))
      w_gnt = 3'b001 << w_p0;
    else if (|(bus.req & (3'b001 << w_p1)))
      w_gnt = 3'b001 << w_p1;
    else if (|(bus.req & (3'b001 << w_p2)))
      w_gnt = 3'b001 << w_p2;
  end

  always_comb begin
    case (w_gnt)
      3'b010:  w_win_idx = 2'd1;
      3'b100:  w_win_idx = 2'd2;
      default: w_win_idx = 2'd0;
    endcase
  end

  // Reset value 2 makes requester 0 the first in line.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset)
      r_ptr <= 2'd2;
    else if (w_accept)
      r_ptr <= w_win_idx;
  end
`else
  always_comb begin
    w_gnt = 3'b000;
    if (bus.req[0])
      w_gnt = 3'b001;
    else if (bus.req[1])
      w_gnt = 3'b010;
    else if (bus.req[2])
      w_gnt = 3'b100;
  end
`endif

  // gnt is always a subset of req, so any grant bit is an acceptance.
  assign w_accept = |w_gnt;

  always_comb begin
    case (w_gnt)
      3'b010:  w_win_addr = bus.addr1;
      3'b100:  w_win_addr = bus.addr2;
      default: w_win_addr = bus.addr0;
    endcase
  end

  // tag1 lines up with rom_address, tag2 with rom_q, rvalid with rdata.
  // A zero tag on idle edges keeps rvalid one cycle wide.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      r_rom_address <= 14'd0;
      r_tag1        <= 3'b000;
      r_tag2        <= 3'b000;
      r_rdata       <= 3'b000;
      r_rvalid      <= 3'b000;
    end else begin
      if (w_accept)
        r_rom_address <= w_win_addr;
      r_tag1   <= w_gnt;
      r_tag2   <= r_tag1;
      r_rdata  <= bus.rom_q;
      r_rvalid <= r_tag2;
    end
  end

  assign bus.gnt         = w_gnt;
  assign bus.rom_address = r_rom_address;
  assign bus.rdata       = r_rdata;
  assign bus.rvalid      = r_rvalid;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - self-checking bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;

  logic vga_clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  sprite_rom_arbiter_if bus ();

  sprite_rom_arbiter dut (
    .vga_clk (vga_clk),
    .Reset   (Reset),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [2:0] rom_fn(input logic [13:0] a);
    return a[2:0] ^ a[7:5] ^ a[13:11] ^ 3'd5;
  endfunction

  // Synchronous sprite ROM stand-in.
  always @(posedge vga_clk) bus.rom_q <= rom_fn(bus.rom_address);

  // Reference model: last winner, current ROM address, and accepted reads
  // awaiting their response, stamped with the accepting edge number.
  typedef struct {
    int          e;
    int          idx;
    logic [13:0] addr;
  } pend_t;

  int          m_ptr;
  logic [13:0] m_rom_addr;
  int          edge_n;
  pend_t       pend[$];

  function automatic int model_winner(input logic [2:0] r);
`ifdef SPRITE_ARB_RR_EN
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + 1 + k) % 3;
      if (r[i]) return i;
    end
`else
    for (int i = 0; i < 3; i++)
      if (r[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr      = 2;
    m_rom_addr = 14'd0;
    pend.delete();
  endtask

  // Drives one cycle starting just after a rising edge; returns observed and
  // model values for the caller to compare.
  task automatic cycle(input logic [2:0] r, input logic [13:0] a0, a1, a2,
                       output logic [2:0] o_gnt, e_gnt, o_rv, e_rv, o_rd, e_rd,
                       output logic [13:0] o_ra, e_ra);
    int          w;
    pend_t       p;
    logic [13:0] wa;
    bus.req   = r;
    bus.addr0 = a0;
    bus.addr1 = a1;
    bus.addr2 = a2;
    #1;
    o_gnt = bus.gnt;
    w     = model_winner(r);
    e_gnt = (w < 0) ? 3'b000 : (3'b001 << w);
    @(posedge vga_clk);
    edge_n++;
    if (w >= 0) begin
      wa = (w == 0) ? a0 : ((w == 1) ? a1 : a2);
      m_ptr      = w;
      m_rom_addr = wa;
      p.e = edge_n; p.idx = w; p.addr = wa;
      pend.push_back(p);
    end
    #1;
    o_ra = bus.rom_address;
    e_ra = m_rom_addr;
    o_rv = bus.rvalid;
    o_rd = bus.rdata;
    e_rv = 3'b000;
    e_rd = 3'b000;
    if (pend.size() > 0 && pend[0].e == edge_n - 2) begin
      p    = pend.pop_front();
      e_rv = 3'b001 << p.idx;
      e_rd = rom_fn(p.addr);
    end
  endtask

  logic [2:0]  og, eg, orv, erv, ord, erd;
  logic [13:0] ora, era;

  task automatic test_reset();
    bus.req = 3'b111; bus.addr0 = 14'h1111; bus.addr1 = 14'h2222; bus.addr2 = 14'h3333;
    Reset = 1'b1;
    model_reset();
    @(posedge vga_clk);
    edge_n++;
    #1;
    checks++;
    if (bus.rom_address !== 14'd0) begin errors++; $display("FAIL reset_rom_address got %h exp 0000", bus.rom_address); end
    checks++;
    if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid got %b exp 000", bus.rvalid); end
    checks++;
    if (bus.rdata !== 3'b000) begin errors++; $display("FAIL reset_rdata got %b exp 000", bus.rdata); end
    checks++;
    if (bus.gnt !== 3'b001) begin errors++; $display("FAIL reset_gnt_comb got %b exp 001", bus.gnt); end
    bus.req = 3'b000;
    #1;
    checks++;
    if (bus.gnt !== 3'b000) begin errors++; $display("FAIL idle_gnt got %b exp 000", bus.gnt); end
    @(posedge vga_clk);
    edge_n++;
    #1;
    Reset = 1'b0;
  endtask

  task automatic test_single();
    cycle(3'b001, 14'h0123, 14'h0, 14'h0, og, eg, orv, erv, ord, erd, ora, era);
    checks++;
    if (og !== 3'b001) begin errors++; $display("FAIL single_gnt got %b exp 001", og); end
    checks++;
    if (ora !== 14'h0123) begin errors++; $display("FAIL single_rom_address got %h exp 0123", ora); end
    for (int i = 0; i < 3; i++) begin
      cycle(3'b000, 14'h0, 14'h0, 14'h0, og, eg, orv, erv, ord, erd, ora, era);
      checks++;
      if (orv !== erv) begin errors++; $display("FAIL single_rvalid[%0d] got %b exp %b", i, orv, erv); end
      if (erv != 3'b000) begin
        checks++;
        if (ord !== rom_fn(14'h0123)) begin errors++; $display("FAIL single_rdata got %b exp %b", ord, rom_fn(14'h0123)); end
      end
    end
  endtask

  task automatic test_all_held();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] r;
      r = (i < 6) ? 3'b111 : 3'b000;
      cycle(r, 14'h0A00 + 14'(i), 14'h1B00 + 14'(i), 14'h2C00 + 14'(i), og, eg, orv, erv, ord, erd, ora, era);
      checks++;
      if (og !== eg) begin errors++; $display("FAIL held_gnt[%0d] got %b exp %b", i, og, eg); end
      checks++;
      if (orv !== erv) begin errors++; $display("FAIL held_rvalid[%0d] got %b exp %b", i, orv, erv); end
      if (erv != 3'b000) begin
        checks++;
        if (ord !== erd) begin errors++; $display("FAIL held_rdata[%0d] got %b exp %b", i, ord, erd); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [4];
    seq[0] = 3'b010; seq[1] = 3'b101; seq[2] = 3'b000; seq[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      cycle(seq[i], 14'h0111, 14'h0222, 14'h0333, og, eg, orv, erv, ord, erd, ora, era);
      checks++;
      if (og !== eg) begin errors++; $display("FAIL b2b_gnt[%0d] got %b exp %b", i, og, eg); end
      checks++;
      if (ora !== era) begin errors++; $display("FAIL b2b_rom_address[%0d] got %h exp %h", i, ora, era); end
      checks++;
      if (orv !== erv) begin errors++; $display("FAIL b2b_rvalid[%0d] got %b exp %b", i, orv, erv); end
    end
  endtask

  task automatic test_reset_in_flight();
    cycle(3'b100, 14'h0, 14'h0, 14'h2ABC, og, eg, orv, erv, ord, erd, ora, era);
    checks++;
    if (ora !== 14'h2ABC) begin errors++; $display("FAIL flight_rom_address got %h exp 2abc", ora); end
    bus.req = 3'b000;
    Reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.rom_address !== 14'd0) begin errors++; $display("FAIL flight_async_rom_address got %h exp 0000", bus.rom_address); end
    @(posedge vga_clk);
    edge_n++;
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(3'b000, 14'h0, 14'h0, 14'h0, og, eg, orv, erv, ord, erd, ora, era);
      checks++;
      if (orv !== 3'b000) begin errors++; $display("FAIL flight_rvalid[%0d] got %b exp 000", i, orv); end
    end
    cycle(3'b111, 14'h0777, 14'h0888, 14'h0999, og, eg, orv, erv, ord, erd, ora, era);
    checks++;
    if (og !== 3'b001) begin errors++; $display("FAIL flight_regrant got %b exp 001", og); end
  endtask

  task automatic test_idle_hold();
    cycle(3'b010, 14'h0, 14'h0050, 14'h0, og, eg, orv, erv, ord, erd, ora, era);
    for (int i = 0; i < 5; i++) begin
      cycle(3'b000, 14'h3FFF, 14'h1234, 14'h2222, og, eg, orv, erv, ord, erd, ora, era);
      checks++;
      if (ora !== 14'h0050) begin errors++; $display("FAIL hold_rom_address[%0d] got %h exp 0050", i, ora); end
      checks++;
      if (orv !== erv) begin errors++; $display("FAIL hold_rvalid[%0d] got %b exp %b", i, orv, erv); end
    end
    cycle(3'b111, 14'h0001, 14'h0002, 14'h0003, og, eg, orv, erv, ord, erd, ora, era);
    checks++;
    if (og !== eg) begin errors++; $display("FAIL hold_ptr_gnt got %b exp %b", og, eg); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [2:0] r;
      r = 3'($urandom_range(0, 7));
      cycle(r, 14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)),
            14'($urandom_range(0, 16383)), og, eg, orv, erv, ord, erd, ora, era);
      checks++;
      if (og !== eg) begin errors++; $display("FAIL rand_gnt[%0d] got %b exp %b", i, og, eg); end
      checks++;
      if (ora !== era) begin errors++; $display("FAIL rand_rom_address[%0d] got %h exp %h", i, ora, era); end
      checks++;
      if (orv !== erv) begin errors++; $display("FAIL rand_rvalid[%0d] got %b exp %b", i, orv, erv); end
      checks++;
      if ($countones(orv) > 1) begin errors++; $display("FAIL rand_rvalid_onehot[%0d] got %b exp at most one bit", i, orv); end
      if (erv != 3'b000) begin
        checks++;
        if (ord !== erd) begin errors++; $display("FAIL rand_rdata[%0d] got %b exp %b", i, ord, erd); end
      end
    end
  endtask

  initial begin
    edge_n = 0;
    bus.req = 3'b000; bus.addr0 = 14'd0; bus.addr1 = 14'd0; bus.addr2 = 14'd0;
    test_reset();
    test_single();
    test_all_held();
    test_back_to_back();
    test_reset_in_flight();
    test_idle_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
